// File: rtl/sqrt_result_logger.sv
// -----------------------------------------------------------------------------
// sqrt_result_logger
//
// Captures one {N, Sqrt} result from a square-root core per Done high period
// and stores it in a 16 x 12 result buffer, in capture order. The buffer can be
// read back through a registered read port.
//
// Optional feature (macro SQRT_CHECK_EN): each committed result is checked
// against Sqrt*Sqrt <= N < (Sqrt+1)*(Sqrt+1). Failures are counted in ErrCount,
// which saturates at 31, and are flagged in ErrFlag. Without the macro, both
// outputs are tied to 0 and there is no checker logic.
//
// Ports:
//   CLK       in   1  clock; all state changes occur on its rising edge
//   ResetN    in   1  asynchronous active-low reset
//   Done      in   1  completion level from the square-root core
//   Sqrt      in   4  root result, valid while Done=1
//   N         in   8  radicand, valid while Done=1
//   Clear     in   1  synchronous clear of Count/WrPtr/Overflow/errors
//   RdAddr    in   4  buffer read address
//   RdData    out 12  {N, Sqrt} at RdAddr, available one cycle later
//   Ack       out  1  one-cycle pulse when a result is captured (WRITE state)
//   Count     out  5  number of stored entries, 0..16
//   Full      out  1  Count == 16
//   Overflow  out  1  sticky: a result was dropped while the buffer was Full
//   ErrCount  out  5  checker failures, saturating at 31
//   ErrFlag   out  1  sticky: any checker failure
// -----------------------------------------------------------------------------
module sqrt_result_logger (
   input  logic        CLK,
   input  logic        ResetN,
   input  logic        Done,
   input  logic [3:0]  Sqrt,
   input  logic [7:0]  N,
   input  logic        Clear,
   input  logic [3:0]  RdAddr,
   output logic [11:0] RdData,
   output logic        Ack,
   output logic [4:0]  Count,
   output logic        Full,
   output logic        Overflow,
   output logic [4:0]  ErrCount,
   output logic        ErrFlag
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_WAIT_LOW = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] hold_q, hold_d;
   logic [3:0]  wr_ptr_q, wr_ptr_d;
   logic [4:0]  count_q, count_d;
   logic        overflow_q, overflow_d;
   logic [11:0] rd_data_q;
   logic [11:0] mem_q [16];

   logic        full;
   logic        commit;
   logic        drop;

   assign full = (count_q == 5'd16);

   // A result leaves WRITE either into the buffer (commit) or dropped; Clear
   // in the same cycle wins over both.
   assign commit = (state_q == ST_WRITE) && !Clear && !full;
   assign drop   = (state_q == ST_WRITE) && !Clear &&  full;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      case (state_q)
         ST_IDLE: begin
            if (Done) begin
               hold_d  = {N, Sqrt};
               state_d = ST_WRITE;
            end
         end
         ST_WRITE:    state_d = ST_WAIT_LOW;
         ST_WAIT_LOW: if (!Done) state_d = ST_IDLE;
         default:     state_d = ST_WAIT_LOW;
      endcase

      if (commit) begin
         wr_ptr_d = wr_ptr_q + 4'd1;   // wraps 15 -> 0 on the 16th write
         count_d  = count_q + 5'd1;
      end
      if (drop) overflow_d = 1'b1;

      // Waiting for Done low after Clear keeps a still-high Done from being
      // captured a second time.
      if (Clear) begin
         state_d    = ST_WAIT_LOW;
         wr_ptr_d   = 4'd0;
         count_d    = 5'd0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         state_q    <= ST_WAIT_LOW;
         hold_q     <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Buffer storage is intentionally not reset so it maps onto block RAM.
   always_ff @(posedge CLK) begin
      if (commit) mem_q[wr_ptr_q] <= hold_q;
   end

   // Read-before-write: same-address access at one edge returns old data.
   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) rd_data_q <= '0;
      else         rd_data_q <= mem_q[RdAddr];
   end

`ifdef SQRT_CHECK_EN
   logic [8:0] root_ext;
   logic [8:0] lo_sq;
   logic [8:0] hi_sq;
   logic [8:0] rad_ext;
   logic       chk_fail;
   logic [4:0] err_count_q, err_count_d;
   logic       err_flag_q, err_flag_d;

   // 9-bit products: (15+1)^2 = 256 needs the ninth bit.
   always_comb begin
      root_ext = {5'd0, hold_q[3:0]};
      rad_ext  = {1'b0, hold_q[11:4]};
      lo_sq    = root_ext * root_ext;
      hi_sq    = (root_ext + 9'd1) * (root_ext + 9'd1);
      chk_fail = !((lo_sq <= rad_ext) && (rad_ext < hi_sq));
   end

   always_comb begin
      err_count_d = err_count_q;
      err_flag_d  = err_flag_q;
      if (commit && chk_fail) begin
         if (err_count_q != 5'd31) err_count_d = err_count_q + 5'd1;
         err_flag_d = 1'b1;
      end
      if (Clear) begin
         err_count_d = 5'd0;
         err_flag_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         err_count_q <= '0;
         err_flag_q  <= 1'b0;
      end else begin
         err_count_q <= err_count_d;
         err_flag_q  <= err_flag_d;
      end
   end

   assign ErrCount = err_count_q;
   assign ErrFlag  = err_flag_q;
`else
   assign ErrCount = 5'd0;
   assign ErrFlag  = 1'b0;
`endif

   assign RdData   = rd_data_q;
   assign Ack      = (state_q == ST_WRITE);
   assign Count    = count_q;
   assign Full     = full;
   assign Overflow = overflow_q;

endmodule

// File: tb/tb_sqrt_result_logger.sv
module tb_sqrt_result_logger;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        done = 1'b0;
   logic [3:0]  sqrt_in = '0;
   logic [7:0]  n_in = '0;
   logic        clear = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic [11:0] rd_data;
   logic        ack;
   logic [4:0]  count;
   logic        full;
   logic        overflow;
   logic [4:0]  err_count;
   logic        err_flag;

   sqrt_result_logger dut (
      .CLK      (clk),
      .ResetN   (rst_n),
      .Done     (done),
      .Sqrt     (sqrt_in),
      .N        (n_in),
      .Clear    (clear),
      .RdAddr   (rd_addr),
      .RdData   (rd_data),
      .Ack      (ack),
      .Count    (count),
      .Full     (full),
      .Overflow (overflow),
      .ErrCount (err_count),
      .ErrFlag  (err_flag)
   );

   always #5 clk = ~clk;

   // Reference model: what the buffer should hold and the status counters.
   logic [11:0] exp_mem [16];
   bit          exp_valid [16];
   int          exp_count = 0;
   int          exp_wr = 0;
   int          exp_ovf = 0;
   int          exp_err = 0;

   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int isqrt(input int n);
      int r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      return r;
   endfunction

   function automatic bit root_ok(input int n, input int s);
      return (s * s <= n) && (n < (s + 1) * (s + 1));
   endfunction

   task automatic model_clear();
      exp_count = 0;
      exp_wr    = 0;
      exp_ovf   = 0;
      exp_err   = 0;
   endtask

   task automatic model_commit(input logic [7:0] n, input logic [3:0] s);
      if (exp_count == 16) begin
         exp_ovf = 1;
      end else begin
         exp_mem[exp_wr]   = {n, s};
         exp_valid[exp_wr] = 1'b1;
         exp_wr            = (exp_wr + 1) % 16;
         exp_count++;
`ifdef SQRT_CHECK_EN
         if (!root_ok(int'(n), int'(s)) && exp_err < 31) exp_err++;
         else if (!root_ok(int'(n), int'(s))) exp_err = 31;
`endif
      end
   endtask

   task automatic check_status(input string tag);
      check_val({tag, "_count"}, 32'(count), 32'(exp_count));
      check_val({tag, "_full"}, 32'(full), 32'(exp_count == 16));
      check_val({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      check_val({tag, "_errcnt"}, 32'(err_count), 32'(exp_err));
      check_val({tag, "_errflag"}, 32'(err_flag), 32'(exp_err != 0));
   endtask

   // One Done high period of len cycles; optionally Clear during WRITE.
   task automatic pulse(input logic [7:0] n, input logic [3:0] s, input int len, input bit clr_in_write);
      logic [11:0] old_val;
      bit          old_valid;
      n_in    = n;
      sqrt_in = s;
      done    = 1'b1;
      tick();                                   // capture edge
      check_val("ack_write", 32'(ack), 32'd1);
      n_in    = 8'($urandom);                   // must not disturb held value
      sqrt_in = 4'($urandom);
      if (len == 1) done = 1'b0;
      rd_addr   = 4'(exp_wr);                   // read the slot being written
      old_val   = exp_mem[exp_wr];
      old_valid = exp_valid[exp_wr];
      if (clr_in_write) clear = 1'b1;
      tick();                                   // write edge
      clear = 1'b0;
      if (clr_in_write) model_clear();
      else              model_commit(n, s);
      check_val("ack_low", 32'(ack), 32'd0);
      if (old_valid) check_val("rd_old_on_write", 32'(rd_data), 32'(old_val));
      check_status("wr");
      for (int i = 2; i < len; i++) begin
         tick();
         check_val("ack_hold", 32'(ack), 32'd0);
      end
      done = 1'b0;
      tick();
      tick();
   endtask

   task automatic read_check(input int addr);
      rd_addr = 4'(addr);
      tick();
      if (exp_valid[addr]) check_val("rd", 32'(rd_data), 32'(exp_mem[addr]));
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
      check_status("clr");
      tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         exp_valid[i] = 1'b0;
         exp_mem[i]   = '0;
      end

      // Reset with Done held high; no capture until Done falls and rises.
      done = 1'b1;
      tick();
      tick();
      check_val("rst_ack", 32'(ack), 32'd0);
      check_val("rst_rddata", 32'(rd_data), 32'd0);
      check_status("rst");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("done_high_no_ack", 32'(ack), 32'd0);
      end
      check_val("done_high_count", 32'(count), 32'd0);
      done = 1'b0;
      tick();
      tick();

      // Basic capture, 3-cycle Done pulse.
      pulse(8'h51, 4'h9, 3, 1'b0);
      read_check(0);
      check_val("first_entry", 32'(rd_data), 32'h519);

      // Fill to 16 and overflow with a 17th pulse.
      do_clear();
      for (int i = 0; i <= 16; i++) pulse(8'(i), 4'(isqrt(i)), $urandom_range(1, 3), 1'b0);
      read_check(15);
      check_val("entry15", 32'(rd_data), 32'h0F3);
      check_val("full_after_17", 32'(full), 32'd1);
      check_val("ovf_after_17", 32'(overflow), 32'd1);

      // Clear coincident with WRITE while full: Clear wins, buffer intact.
      pulse(8'h20, 4'h5, 2, 1'b1);
      read_check(0);
      pulse(8'h31, 4'h7, 1, 1'b0);             // WrPtr restarted at 0
      read_check(0);

      // Checker cases: one bad root, one good root.
      pulse(8'h10, 4'h3, 1, 1'b0);
      pulse(8'hFF, 4'hF, 2, 1'b0);
`ifdef SQRT_CHECK_EN
      check_val("errcount_case", 32'(err_count), 32'd1);
      check_val("errflag_case", 32'(err_flag), 32'd1);
`else
      check_val("errcount_case", 32'(err_count), 32'd0);
      check_val("errflag_case", 32'(err_flag), 32'd0);
`endif

      // Reset asserted during WRITE aborts the write.
      n_in    = 8'h40;
      sqrt_in = 4'h8;
      done    = 1'b1;
      tick();
      check_val("midwr_ack_before", 32'(ack), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("midwr_ack_now", 32'(ack), 32'd0);
      check_val("midwr_count", 32'(count), 32'd0);
      check_val("midwr_rddata", 32'(rd_data), 32'd0);
      tick();
      rst_n = 1'b1;
      model_clear();
      tick();
      check_val("midwr_wait_low", 32'(ack), 32'd0);
      check_status("midwr");
      done = 1'b0;
      tick();
      tick();

      // Randomized traffic.
      for (int it = 0; it < 60; it++) begin
         int r;
         logic [7:0] rn;
         logic [3:0] rs;
         r  = $urandom_range(0, 9);
         rn = 8'($urandom);
         rs = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(isqrt(int'(rn)));
         if (r == 0)      do_clear();
         else if (r == 1) read_check($urandom_range(0, 15));
         else             pulse(rn, rs, $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
      end
      for (int a = 0; a < 16; a++) read_check(a);
      check_status("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
